// File: rtl/mem_responder.sv
// Multi-cycle memory responder: one read/write per transaction, LATENCY wait cycles, one-cycle ready pulse.
// Optional macro MEM_PROTO_CHK_EN adds a sticky proto_err flag for requester protocol violations.
module mem_responder #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
`ifdef MEM_PROTO_CHK_EN
    output logic              busy,
    output logic              proto_err
`else
    output logic              busy
`endif
);

    localparam int           DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]   CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                mem_we_s;
    logic                req_s;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    assign req_s = mem_read | mem_write;

    // Next-state, request capture and completion logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    adr_d   = adr;
                    wdata_d = wdata;
                    wr_d    = mem_write;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // The op is committed on the same edge that enters RESP
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    if (wr_q) begin
                        mem_we_s = 1'b1;
                    end else begin
                        rdata_d = mem_q[adr_q];
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array; contents survive reset, but a write pending at reset is dropped
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            mem_q[adr_q] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;

`ifdef MEM_PROTO_CHK_EN
    logic proto_q, proto_d;

    // Sticky flag: dual request at acceptance, or any request during RESP
    always_comb begin
        proto_d = proto_q;
        if ((state_q == ST_IDLE && mem_read && mem_write) ||
            (state_q == ST_RESP && req_s)) begin
            proto_d = 1'b1;
        end else begin
            proto_d = proto_q;
        end
    end

    // Protocol error flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_q <= 1'b0;
        end else begin
            proto_q <= proto_d;
        end
    end

    assign proto_err = proto_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder at LATENCY 1, 2 and 4 (shared stimulus).
// Most checks target the LATENCY=2 instance; the latency sweep checks all three.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] adr;
    logic [7:0] wdata;
    logic [7:0] rdata1, rdata2, rdata4;
    logic       ready1, ready2, ready4;
    logic       busy1, busy2, busy4;
`ifdef MEM_PROTO_CHK_EN
    logic       perr1, perr2, perr4;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(8), .ADDR_W(5), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .adr(adr), .wdata(wdata), .rdata(rdata1), .ready(ready1),
`ifdef MEM_PROTO_CHK_EN
        .busy(busy1), .proto_err(perr1));
`else
        .busy(busy1));
`endif

    mem_responder #(.DATA_W(8), .ADDR_W(5), .LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .adr(adr), .wdata(wdata), .rdata(rdata2), .ready(ready2),
`ifdef MEM_PROTO_CHK_EN
        .busy(busy2), .proto_err(perr2));
`else
        .busy(busy2));
`endif

    mem_responder #(.DATA_W(8), .ADDR_W(5), .LATENCY(4)) u4 (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .adr(adr), .wdata(wdata), .rdata(rdata4), .ready(ready4),
`ifdef MEM_PROTO_CHK_EN
        .busy(busy4), .proto_err(perr4));
`else
        .busy(busy4));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write, then wait until the slowest instance is idle again
    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        mem_write = 1'b1; adr = a; wdata = d;
        tick();
        mem_write = 1'b0;
        repeat (5) tick();
    endtask

    // Read on the LATENCY=2 instance and check data at the ready pulse
    task automatic do_read(input string tag, input logic [4:0] a, input logic [7:0] exp);
        mem_read = 1'b1; adr = a;
        tick();
        mem_read = 1'b0;
        tick();
        chk({tag, "_rdy_e1"}, 32'(ready2), 32'd0);
        tick();
        chk({tag, "_rdy_e2"}, 32'(ready2), 32'd1);
        chk({tag, "_data"}, 32'(rdata2), 32'(exp));
        tick();
        chk({tag, "_rdy_e3"}, 32'(ready2), 32'd0);
        chk({tag, "_hold"}, 32'(rdata2), 32'(exp));
        repeat (2) tick();
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; adr = 5'd0; wdata = 8'd0;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_ready", 32'(ready2), 32'd0);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_rdata", 32'(rdata2), 32'd0);
`ifdef MEM_PROTO_CHK_EN
        chk("rst_perr", 32'(perr2), 32'd0);
`endif

        // Write 0xA3 to adr 5; wdata changes after acceptance must not matter
        mem_write = 1'b1; adr = 5'd5; wdata = 8'hA3;
        tick();
        mem_write = 1'b0; wdata = 8'hFF; adr = 5'd6;
        chk("wr_busy_e0", 32'(busy2), 32'd1);
        chk("wr_rdy_e0", 32'(ready2), 32'd0);
        tick();
        chk("wr_rdy_e1", 32'(ready2), 32'd0);
        tick();
        chk("wr_rdy_e2", 32'(ready2), 32'd1);
        chk("wr_rdata", 32'(rdata2), 32'd0);
        tick();
        chk("wr_rdy_e3", 32'(ready2), 32'd0);
        chk("wr_busy_e3", 32'(busy2), 32'd0);
        repeat (2) tick();

        // Latency sweep: read adr 5 on all three instances
        mem_read = 1'b1; adr = 5'd5;
        tick();
        mem_read = 1'b0;
        chk("lat4_busy_e0", 32'(busy4), 32'd1);
        for (int k = 0; k <= 5; k++) begin
            chk($sformatf("lat1_rdy_e%0d", k), 32'(ready1), 32'(k == 1));
            chk($sformatf("lat2_rdy_e%0d", k), 32'(ready2), 32'(k == 2));
            chk($sformatf("lat4_rdy_e%0d", k), 32'(ready4), 32'(k == 4));
            if (k == 1) chk("lat1_data", 32'(rdata1), 32'hA3);
            if (k == 2) chk("lat2_data", 32'(rdata2), 32'hA3);
            if (k == 4) chk("lat4_data", 32'(rdata4), 32'hA3);
            if (k < 5) tick();
        end
        chk("lat4_busy_e5", 32'(busy4), 32'd0);
        chk("lat2_hold", 32'(rdata2), 32'hA3);
        tick();

        // Request changes during WAIT are ignored
        do_write(5'd3, 8'h33);
        do_write(5'd7, 8'h77);
        mem_read = 1'b1; adr = 5'd3;
        tick();
        mem_read = 1'b0; adr = 5'd7; mem_write = 1'b1; wdata = 8'hEE;
        tick();
        mem_write = 1'b0;
        chk("ign_rdy_e1", 32'(ready2), 32'd0);
        tick();
        chk("ign_rdy_e2", 32'(ready2), 32'd1);
        chk("ign_data", 32'(rdata2), 32'h33);
        tick();
        chk("ign_rdy_e3", 32'(ready2), 32'd0);
        tick();
        chk("ign_rdy_e4", 32'(ready2), 32'd0);
        chk("ign_busy_e4", 32'(busy2), 32'd0);
        tick();
        do_read("ign_mem7", 5'd7, 8'h77);

        // Reset during WAIT discards the pending write
        do_write(5'd9, 8'h11);
        mem_write = 1'b1; adr = 5'd9; wdata = 8'h22;
        tick();
        mem_write = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_ready", 32'(ready2), 32'd0);
        chk("mrst_busy", 32'(busy2), 32'd0);
        chk("mrst_rdata", 32'(rdata2), 32'd0);
        repeat (5) tick();
        do_read("mrst_mem9", 5'd9, 8'h11);

        // Read and write together act as a write; rdata keeps 0x11
        mem_read = 1'b1; mem_write = 1'b1; adr = 5'd2; wdata = 8'h5C;
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
`ifdef MEM_PROTO_CHK_EN
        chk("both_perr", 32'(perr2), 32'd1);
`endif
        tick();
        tick();
        chk("both_rdy", 32'(ready2), 32'd1);
        chk("both_rdata", 32'(rdata2), 32'h11);
        repeat (3) tick();
        do_read("both_mem2", 5'd2, 8'h5C);
`ifdef MEM_PROTO_CHK_EN
        chk("both_perr_sticky", 32'(perr2), 32'd1);
`endif

        // Request held through RESP is re-accepted one cycle after IDLE
        reset = 1'b1;
        tick();
        reset = 1'b0;
`ifdef MEM_PROTO_CHK_EN
        chk("hold_perr_clr", 32'(perr2), 32'd0);
`endif
        mem_read = 1'b1; adr = 5'd2;
        repeat (3) tick();
        chk("hold_rdy_e2", 32'(ready2), 32'd1);
        tick();
        chk("hold_rdy_e3", 32'(ready2), 32'd0);
        chk("hold_busy_e3", 32'(busy2), 32'd0);
`ifdef MEM_PROTO_CHK_EN
        chk("hold_perr_e3", 32'(perr2), 32'd1);
`endif
        tick();
        mem_read = 1'b0;
        chk("hold_busy_e4", 32'(busy2), 32'd1);
        tick();
        chk("hold_rdy_e5", 32'(ready2), 32'd0);
        tick();
        chk("hold_rdy_e6", 32'(ready2), 32'd1);
        chk("hold_data", 32'(rdata2), 32'h5C);
        tick();
        chk("hold_rdy_e7", 32'(ready2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
